// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder_pkg
//  Description : Shared types for the data-memory responder.
//                - mem_size_e   : access width encoding carried on req_size
//                - dmem_req_s   : one captured load/store request
//                - dmem_resp_s  : one formatted response
//                - resp_state_e : responder FSM states
//                - extend_load  : right-aligned sign/zero extension helper
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;

  // Access width. Encoding 2'd3 is illegal and reported as an error.
  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  // The size field is kept as raw bits so the illegal encoding can be
  // represented and detected.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        is_unsigned;
  } dmem_req_s;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } dmem_resp_s;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } resp_state_e;

  // Extend a right-aligned byte (raw[7:0]) or half (raw[15:0]) to 32 bits.
  function automatic logic [31:0] extend_load(
    input logic [15:0] raw,
    input logic        is_half,
    input logic        is_unsigned
  );
    logic [31:0] result;
    if (is_half) begin
      result = is_unsigned ? {16'h0000, raw} : {{16{raw[15]}}, raw};
    end else begin
      result = is_unsigned ? {24'h000000, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder_if
//  Description : Request/response bus between the memory stage (master) and
//                the data-memory responder (slave).
//                Request  : req_valid/req_ready handshake carrying req_we,
//                           req_addr (byte address), req_wdata (right-aligned),
//                           req_size, req_unsigned.
//                Response : resp_valid/resp_ready handshake carrying
//                           resp_rdata (right-aligned, extended) and resp_err.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface
`default_nettype wire

// File: rtl/data_mem_responder_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lane_align
//  Description : Combinational byte-lane logic for the data-memory responder.
//                Ports:
//                  addr_lsb     in  : addr[1:0] of the request
//                  size         in  : access size (3 = illegal)
//                  is_unsigned  in  : zero-extend loads when 1
//                  wdata        in  : right-aligned store data
//                  rd_word      in  : RAM word at the addressed index
//                  byte_en      out : lanes a store must write
//                  wr_word      out : store data replicated onto all lanes
//                  ld_data      out : extracted and extended load data
//                  misaligned   out : half on odd address / word not on 4
//                  illegal_size out : size encoding 3
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  addr_lsb,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word,
  output logic [31:0] ld_data,
  output logic        misaligned,
  output logic        illegal_size
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rd_word[7:0];
    case (addr_lsb)
      2'd0:    w_byte = rd_word[7:0];
      2'd1:    w_byte = rd_word[15:8];
      2'd2:    w_byte = rd_word[23:16];
      default: w_byte = rd_word[31:24];
    endcase
  end

  assign w_half = addr_lsb[1] ? rd_word[31:16] : rd_word[15:0];

  // Store data is replicated across the word so that the byte enables alone
  // decide which lanes land; no barrel shifter is needed.
  always_comb begin
    byte_en      = 4'b0000;
    wr_word      = 32'h0000_0000;
    ld_data      = 32'h0000_0000;
    misaligned   = 1'b0;
    illegal_size = 1'b0;
    case (mem_size_e'(size))
      MEM_BYTE: begin
        byte_en = 4'b0001 << addr_lsb;
        wr_word = {4{wdata[7:0]}};
        ld_data = extend_load({8'h00, w_byte}, 1'b0, is_unsigned);
      end
      MEM_HALF: begin
        byte_en    = addr_lsb[1] ? 4'b1100 : 4'b0011;
        wr_word    = {2{wdata[15:0]}};
        ld_data    = extend_load(w_half, 1'b1, is_unsigned);
        misaligned = addr_lsb[0];
      end
      MEM_WORD: begin
        byte_en    = 4'b1111;
        wr_word    = wdata;
        ld_data    = rd_word;
        misaligned = |addr_lsb;
      end
      default: begin
        illegal_size = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Multi-cycle data memory for the pipeline memory stage.
//                Accepts one load/store at a time, performs it against an
//                internal word RAM at the accept edge, and presents the
//                registered response LATENCY cycles later until taken.
//                Parameters:
//                  DEPTH_WORDS : number of 32-bit words (power of two, >= 4)
//                  LATENCY     : accept-to-resp_valid distance in cycles (>= 1)
//                Ports:
//                  clk : clock, all logic on the rising edge
//                  rst : synchronous active-high reset
//                  bus : data_mem_responder_if.slave request/response bus
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int C_IDX_W = $clog2(DEPTH_WORDS);
  // The counter only ever holds LATENCY-1 down to 1.
  localparam int C_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(LATENCY - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  resp_state_e          r_state;
  resp_state_e          w_next_state;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [C_CNT_W-1:0]   w_next_cnt;
  dmem_resp_s           r_resp;
  logic [31:0]          r_mem [DEPTH_WORDS];

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  dmem_req_s            w_req;
  dmem_resp_s           w_resp;
  logic [C_IDX_W-1:0]   w_idx;
  logic [31:0]          w_rd_word;
  logic [3:0]           w_byte_en;
  logic [31:0]          w_wr_word;
  logic [31:0]          w_ld_data;
  logic                 w_misaligned;
  logic                 w_illegal_size;
  logic                 w_out_of_range;
  logic                 w_err;
  logic                 w_accept;
  logic                 w_wr_en;

  assign w_req = '{
    we:          bus.req_we,
    addr:        bus.req_addr,
    wdata:       bus.req_wdata,
    size:        bus.req_size,
    is_unsigned: bus.req_unsigned
  };

  assign w_idx          = w_req.addr[C_IDX_W+1:2];
  // Compare the full word address so high address bits cannot alias into RAM.
  assign w_out_of_range = ({2'b00, w_req.addr[31:2]} >= 32'(DEPTH_WORDS));
  assign w_rd_word      = r_mem[w_idx];

  dmem_lane_align u_lane_align (
    .addr_lsb     (w_req.addr[1:0]),
    .size         (w_req.size),
    .is_unsigned  (w_req.is_unsigned),
    .wdata        (w_req.wdata),
    .rd_word      (w_rd_word),
    .byte_en      (w_byte_en),
    .wr_word      (w_wr_word),
    .ld_data      (w_ld_data),
    .misaligned   (w_misaligned),
    .illegal_size (w_illegal_size)
  );

  assign w_err        = w_misaligned | w_illegal_size | w_out_of_range;
  assign w_resp.err   = w_err;
  // Stores and faulting requests return zero data.
  assign w_resp.rdata = (w_err | w_req.we) ? 32'h0000_0000 : w_ld_data;

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_next_state = ST_RESP;
          end else begin
            w_next_state = ST_WAIT;
            w_next_cnt   = C_CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        // Request inputs are deliberately not looked at here.
        w_next_cnt = r_cnt - C_CNT_ONE;
        if (r_cnt == C_CNT_ONE) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM, counter and response register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_resp  <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_accept) begin
        r_resp <= w_resp;
      end
    end
  end

  // --------------------------------------------------------------------------
  // RAM: written at the accept edge; contents survive reset, but a request
  // presented while rst is high is never accepted.
  // --------------------------------------------------------------------------
  assign w_wr_en = w_accept & ~rst & w_req.we & ~w_err;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_byte_en[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wr_word[8*i +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = (r_state == ST_RESP);
  assign bus.resp_rdata = r_resp.rdata;
  assign bus.resp_err   = r_resp.err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Self-checking bench for data_mem_responder. A byte-addressed
//                reference memory predicts every response of the LATENCY=2
//                instance; a second LATENCY=1 instance is run back to back.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_responder_if bus2 ();
  data_mem_responder_if bus1 ();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: plain byte-addressed memory, little-endian
  // --------------------------------------------------------------------------
  logic [7:0] ref_mem [logic [31:0]];

  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       output logic [31:0] rd, output logic err);
    int n;
    logic [31:0] v;
    n   = 1 << size;
    err = (size == 2'd3) || ((addr % 32'(n)) != 0) || ((addr >> 2) >= 32'(DEPTH));
    rd  = '0;
    v   = '0;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        if (we) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
        else    v = v | (32'(ref_mem[addr + 32'(i)]) << (8*i));
      end
      if (!we && n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      if (!we) rd = v;
    end
  endtask

  // --------------------------------------------------------------------------
  // One full transaction on the LATENCY=2 instance; hold > 0 keeps
  // resp_ready low that many cycles while a spurious store is presented.
  // --------------------------------------------------------------------------
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] size, input logic uns, input int hold,
                     output logic [31:0] rdata, output logic err);
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [31:0] held_rd;
    logic        held_err;
    int          lat;
    rdata = '0;
    err   = 1'b0;
    @(negedge clk);
    check("req_ready_idle", 32'(bus2.req_ready), 32'd1);
    bus2.req_valid    = 1'b1;
    bus2.req_we       = we;
    bus2.req_addr     = addr;
    bus2.req_wdata    = wdata;
    bus2.req_size     = size;
    bus2.req_unsigned = uns;
    model(we, addr, wdata, size, uns, exp_rd, exp_err);
    @(posedge clk);
    @(negedge clk);
    bus2.req_valid = 1'b0;
    lat = 1;
    while (!bus2.resp_valid && lat < 20) begin
      check("req_ready_wait", 32'(bus2.req_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(LAT));
    if (!bus2.resp_valid) return;
    held_rd  = bus2.resp_rdata;
    held_err = bus2.resp_err;
    for (int k = 0; k < hold; k++) begin
      bus2.req_valid = 1'b1;
      bus2.req_we    = 1'b1;
      bus2.req_size  = 2'd2;
      bus2.req_addr  = {addr[31:2], 2'b00};
      bus2.req_wdata = ~wdata;
      @(negedge clk);
      check("hold_valid", 32'(bus2.resp_valid), 32'd1);
      check("hold_rdata", bus2.resp_rdata, held_rd);
      check("hold_err", 32'(bus2.resp_err), 32'(held_err));
      check("hold_req_ready", 32'(bus2.req_ready), 32'd0);
    end
    bus2.req_valid  = 1'b0;
    bus2.resp_ready = 1'b1;
    rdata = bus2.resp_rdata;
    err   = bus2.resp_err;
    check("rdata", rdata, exp_rd);
    check("err", 32'(err), 32'(exp_err));
    @(negedge clk);
    bus2.resp_ready = 1'b0;
    check("resp_valid_after", 32'(bus2.resp_valid), 32'd0);
    check("req_ready_after", 32'(bus2.req_ready), 32'd1);
  endtask

  // LATENCY=1 response monitor
  bit          mon_en = 1'b0;
  logic [31:0] rd_q [$];
  logic        err_q [$];
  always @(negedge clk) begin
    if (mon_en && bus1.resp_valid) begin
      rd_q.push_back(bus1.resp_rdata);
      err_q.push_back(bus1.resp_err);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] data1 [4];
    int          acc_q [$];
    int          edges;
    bit          got;
    bit          rdy;

    rst = 1'b1;
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
    bus2.req_size = 2'd0; bus2.req_unsigned = 1'b0; bus2.resp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    bus1.req_size = 2'd0; bus1.req_unsigned = 1'b0; bus1.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus2.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus2.resp_valid), 32'd0);
    check("rst_resp_rdata", bus2.resp_rdata, 32'd0);
    check("rst_resp_err", 32'(bus2.resp_err), 32'd0);
    rst = 1'b0;

    // Prefill the window used by random traffic (words 0..31)
    for (int w = 0; w < 32; w++) txn(1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0, 0, rd, er);

    // Directed sequence
    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, 0, rd, er);
    txn(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, rd, er);
    check("ld_word_const", rd, 32'hDEAD_BEEF);
    txn(1'b1, 32'h13, 32'h0000_0080, 2'd0, 1'b0, 0, rd, er);
    txn(1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 0, rd, er);
    check("ld_byte_signed_const", rd, 32'hFFFF_FF80);
    txn(1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 0, rd, er);
    check("ld_byte_unsigned_const", rd, 32'h0000_0080);
    txn(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, rd, er);
    check("ld_word_merged_const", rd, 32'h80AD_BEEF);
    txn(1'b0, 32'h12, 32'h0, 2'd1, 1'b0, 0, rd, er);
    check("ld_half_hi_const", rd, 32'hFFFF_80AD);
    txn(1'b0, 32'h11, 32'h0, 2'd1, 1'b0, 0, rd, er);
    check("half_misaligned_err", 32'(er), 32'd1);
    txn(1'b1, 32'h4002, 32'h5555_AAAA, 2'd2, 1'b0, 0, rd, er);
    check("word_store_unaligned_err", 32'(er), 32'd1);
    txn(1'b0, 32'h4000, 32'h0, 2'd2, 1'b0, 0, rd, er);
    txn(1'b0, 32'h1000, 32'h0, 2'd2, 1'b0, 0, rd, er);
    check("out_of_range_err", 32'(er), 32'd1);
    txn(1'b0, 32'h8, 32'h0, 2'd3, 1'b0, 0, rd, er);
    check("illegal_size_err", 32'(er), 32'd1);
    txn(1'b1, 32'hC, 32'h0, 2'd3, 1'b0, 0, rd, er);

    // Backpressure with a spurious store that must be ignored
    txn(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 5, rd, er);
    txn(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, rd, er);
    check("bp_no_spurious_write", rd, 32'h80AD_BEEF);

    // Reset while waiting; then reset coinciding with a request
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_we = 1'b1; bus2.req_addr = 32'h20;
    bus2.req_wdata = 32'h1234_5678; bus2.req_size = 2'd2; bus2.req_unsigned = 1'b0;
    model(1'b1, 32'h20, 32'h1234_5678, 2'd2, 1'b0, rd, er);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus2.req_valid = 1'b1; bus2.req_addr = 32'h24; bus2.req_wdata = 32'hCAFE_F00D;
    check("rst_wait_resp_valid", 32'(bus2.resp_valid), 32'd0);
    @(negedge clk);
    check("rst_hold_resp_valid", 32'(bus2.resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus2.req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("post_rst_resp_valid", 32'(bus2.resp_valid), 32'd0);
      check("post_rst_req_ready", 32'(bus2.req_ready), 32'd1);
      @(negedge clk);
    end
    txn(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0, rd, er);
    check("store_survives_rst", rd, 32'h1234_5678);
    txn(1'b0, 32'h24, 32'h0, 2'd2, 1'b0, 0, rd, er);

    // Randomised traffic
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127));
      txn(1'($urandom), a, $urandom, 2'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0) ? 2 : 0, rd, er);
    end

    // LATENCY=1 back-to-back with resp_ready held high
    for (int i = 0; i < 4; i++) data1[i] = $urandom;
    bus1.resp_ready = 1'b1;
    mon_en = 1'b1;
    edges  = 0;
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      bus1.req_valid    = 1'b1;
      bus1.req_we       = (r < 4);
      bus1.req_addr     = 32'h40 + 32'((r % 4) * 4);
      bus1.req_wdata    = data1[r % 4];
      bus1.req_size     = 2'd2;
      bus1.req_unsigned = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        rdy = bus1.req_ready;
        @(posedge clk);
        edges++;
        if (rdy) begin
          got = 1'b1;
          acc_q.push_back(edges);
        end else begin
          @(negedge clk);
        end
      end
      check("l1_accept", 32'(got), 32'd1);
    end
    @(negedge clk);
    bus1.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    for (int i = 1; i < acc_q.size(); i++) check("l1_gap", 32'(acc_q[i] - acc_q[i-1]), 32'd2);
    check("l1_resp_count", 32'(rd_q.size()), 32'd8);
    for (int i = 0; i < rd_q.size() && i < 8; i++) begin
      check("l1_rdata", rd_q[i], (i < 4) ? 32'h0 : data1[i-4]);
      check("l1_err", 32'(err_q[i]), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
